// File: rtl/weight_fetch_controller.sv
// Weight fetch controller: issues per-lane SRAM reads per request, buffers returns in a credit-limited FIFO
// and unpacks the FIFO head into signed tiles. Define WFC_PERF_CNT_EN to add request/stall counters.
module weight_fetch_controller #(
    parameter int NUM_LANES  = 2,
    parameter int TILE       = 6,
    parameter int ELEM_W     = 12,
    parameter int MEM_W      = 512,
    parameter int ADDR_W     = 8,
    parameter int OD_W       = 8,
    parameter int ID_W       = 4,
    parameter int MEM_LAT    = 1,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [OD_W-1:0]               total_od_i,
    input  logic [OD_W-1:0]               req_od_i,
    input  logic [ID_W-1:0]               req_id_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic                          flush_i,
    output logic [NUM_LANES*ADDR_W-1:0]   mem_addr_o,
    output logic [NUM_LANES-1:0]          mem_rd_en_o,
    input  logic [NUM_LANES*MEM_W-1:0]    mem_data_i,
    input  logic [NUM_LANES-1:0]          mem_valid_i,
    output logic signed [ELEM_W-1:0]      tile_o [NUM_LANES][TILE][TILE],
    output logic [NUM_LANES-1:0]          lane_valid_o,
    output logic [NUM_LANES*OD_W-1:0]     od_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic                          error_o
`ifdef WFC_PERF_CNT_EN
    ,
    output logic [15:0]                   perf_req_o,
    output logic [15:0]                   perf_stall_o
`endif
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 2;
    localparam int FULL_W = OD_W + ID_W + 1;
    localparam int PKG_W  = TILE * TILE * ELEM_W;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_e;

    typedef struct packed {
        logic                        valid;  // return is to be written
        logic                        busy;   // read is outstanding, even if discarded
        logic [NUM_LANES-1:0]        mask;
        logic [NUM_LANES*OD_W-1:0]   od;
    } pipe_t;

    state_e                      state_q, state_d;
    pipe_t                       pipe_q [MEM_LAT];
    pipe_t                       pipe_in, ret;
    logic [CNT_W-1:0]            in_flight_q, in_flight_d, count_q, count_d, occupancy;
    logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q;
    logic                        accept, pop, ret_write, out_valid, error_q;
    logic [OD_W:0]               od_full [NUM_LANES];
    logic [NUM_LANES-1:0]        active;
    logic [NUM_LANES*OD_W-1:0]   req_od_lanes;
    logic [NUM_LANES*PKG_W-1:0]  wr_data, head_data;
    logic [NUM_LANES*PKG_W-1:0]  fifo_data_q [FIFO_DEPTH];
    logic [NUM_LANES-1:0]        fifo_mask_q [FIFO_DEPTH];
    logic [NUM_LANES*OD_W-1:0]   fifo_od_q   [FIFO_DEPTH];
    logic                        unused_mem_bits;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        out_valid   = (count_q != '0);
        pop         = out_valid && out_ready_i && !flush_i;
        occupancy   = in_flight_q + count_q - CNT_W'(pop);
        req_ready_o = !reset && (state_q != S_FLUSH) && !flush_i && (occupancy < CNT_W'(FIFO_DEPTH));
        accept      = req_valid_i && req_ready_o;

        mem_addr_o   = '0;
        mem_rd_en_o  = '0;
        active       = '0;
        req_od_lanes = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            od_full[k]  = {1'b0, req_od_i} + (OD_W+1)'(k);
            active[k]   = od_full[k] < {1'b0, total_od_i};
            req_od_lanes[k*OD_W +: OD_W] = od_full[k][OD_W-1:0];
            if (accept) begin
                mem_rd_en_o[k] = active[k];
                mem_addr_o[k*ADDR_W +: ADDR_W] = ADDR_W'(FULL_W'(od_full[k])
                                                 + FULL_W'(total_od_i) * FULL_W'(req_id_i));
            end
        end

        pipe_in       = '0;
        pipe_in.valid = accept;
        pipe_in.busy  = accept;
        pipe_in.mask  = active;
        pipe_in.od    = req_od_lanes;
    end

    // The oldest pipeline stage is the read returning this cycle; flush discards it.
    always_comb begin
        ret         = pipe_q[MEM_LAT-1];
        ret_write   = ret.valid && !flush_i;
        in_flight_d = in_flight_q + CNT_W'(accept) - CNT_W'(ret.busy);
        count_d     = flush_i ? '0 : count_q + CNT_W'(ret_write) - CNT_W'(pop);

        wr_data         = '0;
        unused_mem_bits = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (ret.mask[k])
                wr_data[k*PKG_W +: PKG_W] = mem_data_i[k*MEM_W +: PKG_W];
            unused_mem_bits = unused_mem_bits ^ (^mem_data_i[k*MEM_W+PKG_W +: MEM_W-PKG_W]);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN:   if (in_flight_q == '0 && count_q == '0 && !accept) state_d = S_IDLE;
            S_FLUSH: if (in_flight_d == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush_i)
            state_d = S_FLUSH;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            in_flight_q <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            error_q     <= 1'b0;
            for (int i = 0; i < MEM_LAT; i++)
                pipe_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            in_flight_q <= in_flight_d;
            count_q     <= count_d;
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (ret_write) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)       rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (ret_write && (mem_valid_i != ret.mask))
                error_q <= 1'b1;
            pipe_q[0] <= pipe_in;
            for (int i = 1; i < MEM_LAT; i++) begin
                pipe_q[i]       <= pipe_q[i-1];
                pipe_q[i].valid <= pipe_q[i-1].valid && !flush_i;
            end
        end
    end

    // NOTE: FIFO storage is not reset; count_q alone decides whether any entry is visible.
    always_ff @(posedge clk) begin
        if (ret_write) begin
            fifo_data_q[wr_ptr_q] <= wr_data;
            fifo_mask_q[wr_ptr_q] <= ret.mask;
            fifo_od_q[wr_ptr_q]   <= ret.od;
        end
    end

    always_comb begin
        out_valid_o  = out_valid;
        error_o      = error_q;
        head_data    = out_valid ? fifo_data_q[rd_ptr_q] : '0;
        lane_valid_o = out_valid ? fifo_mask_q[rd_ptr_q] : '0;
        od_o         = out_valid ? fifo_od_q[rd_ptr_q]   : '0;
        for (int k = 0; k < NUM_LANES; k++)
            for (int i = 0; i < TILE; i++)
                for (int j = 0; j < TILE; j++)
                    tile_o[k][i][j] = head_data[k*PKG_W + (i*TILE+j)*ELEM_W +: ELEM_W];
    end

`ifdef WFC_PERF_CNT_EN
    logic [15:0] perf_req_q, perf_stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_req_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            if (accept && perf_req_q != '1)
                perf_req_q <= perf_req_q + 16'd1;
            if (req_valid_i && !req_ready_o && perf_stall_q != '1)
                perf_stall_q <= perf_stall_q + 16'd1;
        end
    end

    assign perf_req_o   = perf_req_q;
    assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_weight_fetch_controller.sv
// Directed bench for weight_fetch_controller with a one-cycle SRAM model driven from the tick task.
module tb_weight_fetch_controller;

    localparam int NL = 2, TILE = 6, EW = 12, MW = 512, AW = 8, OW = 8, IW = 4;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [OW-1:0]            total_od_i, req_od_i;
    logic [IW-1:0]            req_id_i;
    logic                     req_valid_i, req_ready_o, flush_i;
    logic [NL*AW-1:0]         mem_addr_o;
    logic [NL-1:0]            mem_rd_en_o, mem_valid_i, lane_valid_o;
    logic [NL*MW-1:0]         mem_data_i;
    logic signed [EW-1:0]     tile_o [NL][TILE][TILE];
    logic [NL*OW-1:0]         od_o;
    logic                     out_valid_o, out_ready_i, error_o;
    logic [NL-1:0]            withhold;

    int num_checks = 0;
    int num_errors = 0;

    weight_fetch_controller dut (
        .clk(clk), .reset(reset), .total_od_i(total_od_i), .req_od_i(req_od_i),
        .req_id_i(req_id_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .flush_i(flush_i), .mem_addr_o(mem_addr_o), .mem_rd_en_o(mem_rd_en_o),
        .mem_data_i(mem_data_i), .mem_valid_i(mem_valid_i), .tile_o(tile_o),
        .lane_valid_o(lane_valid_o), .od_o(od_o), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .error_o(error_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        num_checks++;
        if (got != exp) begin
            num_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [EW-1:0] elem(input int addr, input int e);
        return EW'((e - 18) * 100 + addr);
    endfunction

    // Advance one clock; the SRAM answers the reads strobed in the cycle just ended.
    task automatic tick();
        logic [NL-1:0]    en;
        logic [NL*AW-1:0] addr;
        en   = mem_rd_en_o;
        addr = mem_addr_o;
        @(posedge clk);
        #1;
        mem_valid_i = en & ~withhold;
        mem_data_i  = '0;
        for (int k = 0; k < NL; k++)
            for (int e = 0; e < TILE*TILE; e++)
                mem_data_i[k*MW + e*EW +: EW] = elem(int'(addr[k*AW +: AW]), e);
    endtask

    task automatic wait_out(input string tag);
        int n = 0;
        while (!out_valid_o && n < 8) begin
            tick();
            n++;
        end
        check(tag, int'(out_valid_o), 1);
    endtask

    task automatic pop_head();
        out_ready_i = 1'b1;
        #1;
        tick();
        out_ready_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nz;
        reset = 1'b1; total_od_i = 8'd16; req_od_i = '0; req_id_i = '0; req_valid_i = 1'b1;
        flush_i = 1'b0; out_ready_i = 1'b0; mem_data_i = '0; mem_valid_i = '0; withhold = '0;
        #12;
        check("rst_ready", int'(req_ready_o), 0);
        check("rst_rd_en", int'(mem_rd_en_o), 0);
        check("rst_addr", int'(mem_addr_o), 0);
        check("rst_out_valid", int'(out_valid_o), 0);
        check("rst_lane_valid", int'(lane_valid_o), 0);
        check("rst_tile", tile_o[0][1][2], 0);
        check("rst_error", int'(error_o), 0);
        req_valid_i = 1'b0;
        @(negedge clk) reset = 1'b0;
        tick();

        // Full request: od=4 id=2 total_od=16
        req_od_i = 8'd4; req_id_i = 4'd2; req_valid_i = 1'b1;
        #1;
        check("t1_ready", int'(req_ready_o), 1);
        check("t1_addr0", int'(mem_addr_o[0 +: AW]), 36);
        check("t1_addr1", int'(mem_addr_o[AW +: AW]), 37);
        check("t1_rd_en", int'(mem_rd_en_o), 3);
        tick();
        req_valid_i = 1'b0;
        wait_out("t1_out_valid");
        check("t1_od0", int'(od_o[0 +: OW]), 4);
        check("t1_od1", int'(od_o[OW +: OW]), 5);
        check("t1_lane_valid", int'(lane_valid_o), 3);
        check("t1_tile0_1_2", tile_o[0][1][2], -964);
        check("t1_tile1_5_5", tile_o[1][5][5], 1737);
        pop_head();
        check("t1_popped", int'(out_valid_o), 0);

        // Partial request: lane 1 out of range
        total_od_i = 8'd5; req_od_i = 8'd4; req_id_i = 4'd0; req_valid_i = 1'b1;
        #1;
        check("t2_rd_en", int'(mem_rd_en_o), 1);
        check("t2_addr0", int'(mem_addr_o[0 +: AW]), 4);
        tick();
        req_valid_i = 1'b0;
        wait_out("t2_out_valid");
        check("t2_lane_valid", int'(lane_valid_o), 1);
        nz = 0;
        for (int i = 0; i < TILE; i++)
            for (int j = 0; j < TILE; j++)
                if (tile_o[1][i][j] != 0) nz++;
        check("t2_lane1_zero", nz, 0);
        check("t2_tile0_0_0", tile_o[0][0][0], -1796);
        check("t2_error", int'(error_o), 0);
        pop_head();

        // Credit limit and FIFO ordering
        total_od_i = 8'd16; req_id_i = 4'd0;
        req_od_i = 8'd0; req_valid_i = 1'b1;
        #1; check("t3_ready_a", int'(req_ready_o), 1);
        tick();
        req_od_i = 8'd2;
        #1; check("t3_ready_b", int'(req_ready_o), 1);
        tick();
        req_od_i = 8'd4;
        #1; check("t3_credit_full", int'(req_ready_o), 0);
        check("t3_no_rd_en", int'(mem_rd_en_o), 0);
        tick(); tick();
        check("t3_credit_hold", int'(req_ready_o), 0);
        check("t3_head_a", int'(od_o[0 +: OW]), 0);
        out_ready_i = 1'b1;
        #1; check("t3_pop_frees_credit", int'(req_ready_o), 1);
        tick();
        req_valid_i = 1'b0;
        check("t3_head_b", int'(od_o[0 +: OW]), 2);
        tick();
        out_ready_i = 1'b0;
        wait_out("t3_out_valid_c");
        check("t3_head_c", int'(od_o[0 +: OW]), 4);
        pop_head();
        check("t3_empty", int'(out_valid_o), 0);

        // Flush with one group buffered and one read in flight
        req_od_i = 8'd0; req_valid_i = 1'b1;
        #1; tick();
        req_od_i = 8'd8;
        #1; check("t4_ready_b", int'(req_ready_o), 1);
        tick();
        req_valid_i = 1'b0; flush_i = 1'b1;
        #1;
        check("t4_flush_blocks_ready", int'(req_ready_o), 0);
        check("t4_buffered", int'(out_valid_o), 1);
        tick();
        flush_i = 1'b0;
        #1;
        check("t4_flush_empties", int'(out_valid_o), 0);
        check("t4_flush_state_ready", int'(req_ready_o), 0);
        tick();
        check("t4_back_to_idle", int'(req_ready_o), 1);
        tick(); tick();
        check("t4_return_discarded", int'(out_valid_o), 0);
        req_od_i = 8'd6; req_id_i = 4'd1; req_valid_i = 1'b1;
        #1; check("t4_next_addr0", int'(mem_addr_o[0 +: AW]), 22);
        tick();
        req_valid_i = 1'b0;
        wait_out("t4_next_out_valid");
        check("t4_next_od0", int'(od_o[0 +: OW]), 6);
        check("t4_next_lane_valid", int'(lane_valid_o), 3);
        pop_head();

        // Missing return valid on active lane 1
        withhold = 2'b10; req_od_i = 8'd0; req_id_i = 4'd0; req_valid_i = 1'b1;
        #1; tick();
        req_valid_i = 1'b0; withhold = '0;
        wait_out("t5_out_valid");
        check("t5_error_set", int'(error_o), 1);
        pop_head();
        tick(); tick(); tick();
        check("t5_error_sticky", int'(error_o), 1);

        // Asynchronous reset with a group buffered
        req_valid_i = 1'b1;
        #1; tick();
        req_valid_i = 1'b0;
        tick();
        check("t6_buffered", int'(out_valid_o), 1);
        #2 reset = 1'b1;
        #1;
        check("t6_out_valid", int'(out_valid_o), 0);
        check("t6_lane_valid", int'(lane_valid_o), 0);
        check("t6_od", int'(od_o), 0);
        check("t6_tile", tile_o[0][0][0], 0);
        check("t6_error", int'(error_o), 0);
        check("t6_ready", int'(req_ready_o), 0);
        @(negedge clk) reset = 1'b0;
        tick(); tick();
        check("t6_post_reset_empty", int'(out_valid_o), 0);
        check("t6_post_reset_ready", int'(req_ready_o), 1);

        $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
        $finish;
    end

endmodule

// File: doc/weight_fetch_controller.md
Name: weight_fetch_controller

Overview:
- Parametrised successor to the two-lane weight controller: accepts weight-fetch requests from the main controller and issues NUM_LANES SRAM reads per request at addresses od_base+k + total_od*id.
- Tracks in-flight reads through a MEM_LAT pipeline and buffers returned packages in a credit-limited FIFO.
- Unpacks each package into TILE x TILE signed tiles and hands them to the PE arrays over a valid/ready handshake.
- Lanes whose output depth is out of range (>= total_od) are masked.

Parameters:
- NUM_LANES, 2, weight packages (output depths) fetched per request
- TILE, 6, tile edge; TILE*TILE*ELEM_W must be <= MEM_W
- ELEM_W, 12, signed weight element width
- MEM_W, 512, SRAM word width
- ADDR_W, 8, SRAM address width
- OD_W, 8, output-depth index width
- ID_W, 4, input-depth index width
- MEM_LAT, 1, fixed SRAM read latency in cycles (>= 1)
- FIFO_DEPTH, 2, buffered request groups (power of 2, >= 2)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- total_od_i  in  OD_W  total output depth, static while not idle
- req_od_i  in  OD_W  base output depth of request
- req_id_i  in  ID_W  input-depth index
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&&ready
- flush_i  in  1  discard all in-flight and buffered data
- mem_addr_o  out  NUM_LANES*ADDR_W  per-lane read address, lane k at [k*ADDR_W +: ADDR_W]
- mem_rd_en_o  out  NUM_LANES  per-lane read strobe
- mem_data_i  in  NUM_LANES*MEM_W  per-lane read data
- mem_valid_i  in  NUM_LANES  per-lane read-data valid
- tile_o  out  [NUM_LANES][TILE][TILE] x ELEM_W signed  unpacked tiles of FIFO head
- lane_valid_o  out  NUM_LANES  lane holds a real (unmasked) tile
- od_o  out  NUM_LANES*OD_W  output depth per lane
- out_valid_o  out  1  FIFO head valid
- out_ready_i  in  1  PE arrays accept head
- error_o  out  1  sticky: return-valid mismatch

Behaviour:
- Reset (async, reset=1): req_ready_o=0, mem_rd_en_o=0, mem_addr_o=0, out_valid_o=0, lane_valid_o=0, od_o=0, tile_o all 0, error_o=0; FIFO empty; in-flight count 0; FSM=IDLE. Reset mid-operation drops everything; returns arriving after reset are ignored.
- FSM states: IDLE (nothing in flight, FIFO empty), RUN (any in flight or buffered), FLUSH (draining in-flight returns after flush_i).
  - IDLE -> RUN on accept.
  - RUN -> IDLE when in-flight=0 and FIFO empty.
  - any -> FLUSH on flush_i; FLUSH -> IDLE once in-flight=0.
- req_ready_o=1 iff state!=FLUSH and flush_i=0 and (in_flight + fifo_count) < FIFO_DEPTH. req_ready_o is combinational.
- On accept (cycle T), for lane k:
  - od_k = req_od_i+k (OD_W+1 bits).
  - Lane active iff od_k < total_od_i.
  - mem_addr_o[k] = (od_k + total_od_i*req_id_i) truncated to ADDR_W.
  - mem_rd_en_o[k] = active. Address and strobe are combinational in cycle T.
  - A MEM_LAT-deep pipeline carries {od per lane, active mask, valid}.
- Return at cycle T+MEM_LAT:
  - Active lanes must see mem_valid_i[k]=1; inactive lanes must see 0. Any mismatch sets error_o (cleared only by reset). The group is still written.
  - Data for inactive lanes is stored as 0.
  - Write into the FIFO; credits guarantee no overflow.
- Output:
  - Head is shown combinationally from FIFO storage.
  - tile_o[k][i][j] = data_k[(i*TILE+j)*ELEM_W +: ELEM_W].
  - od_o[k] = od_k truncated to OD_W.
  - Pop on out_valid_o && out_ready_i.
  - Empty FIFO: out_valid_o=0, lane_valid_o=0, tile_o=0.
- Simultaneous events:
  - Pop and return in the same cycle: both occur, count unchanged.
  - A pop frees its credit the same cycle, so req_ready_o may rise that cycle.
  - Accept and return in the same cycle: in-flight count unchanged.
- flush_i: FIFO emptied next cycle and out_valid_o=0. The pipeline is marked invalid so its returns are discarded. flush_i has priority over req_valid_i and out_ready_i. No accept occurs in FLUSH.
- total_od_i=0: all lanes inactive; the request is still accepted and produces a group with lane_valid_o=0 on all lanes.

Optional Feature:
- WFC_PERF_CNT_EN: when defined, adds outputs perf_req_o (16b) and perf_stall_o (16b), both saturating and reset to 0.
  - perf_req_o counts accepted requests.
  - perf_stall_o counts cycles with req_valid_i=1 and req_ready_o=0.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Defaults, total_od=16, request od=4 id=2 -> cycle T: addrs 36,37 with rd_en=11; T+1: out_valid=1, od_o={5,4}, tile_o[0][1][2] = data_0[96:107].
- total_od=5, request od=4 -> rd_en=01, lane_valid_o=01, lane 1 tile all 0, error_o=0.
- out_ready=0, three back-to-back requests -> first two accepted, req_ready_o=0 on the third until a pop; FIFO order is preserved.
- flush_i asserted while one read is in flight and one group is buffered -> out_valid=0 next cycle; the in-flight return is discarded; state returns to IDLE; the next request proceeds normally.
- mem_valid_i withheld on an active lane -> error_o=1 and stays 1 until reset; async reset mid-RUN -> all outputs 0 immediately.
